// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The state enum here is the only encoding of the divider FSM.
package seq_div_pkg;

   localparam int DIVIDEND_W = 16;
   localparam int DIVISOR_W  = 8;
   localparam int STEP_COUNT = 16;
   localparam int COUNT_W    = 5;
   localparam int PARTIAL_W  = DIVISOR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : seq_div_pkg

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module div_step
   import seq_div_pkg::*;
(
   input  logic [PARTIAL_W-1:0] partial,
   input  logic                 next_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [PARTIAL_W-1:0] new_partial,
   output logic                 q_bit
);

   logic [PARTIAL_W-1:0] shifted;
   logic [PARTIAL_W-1:0] divisor_ext;

   // Compare/subtract on the shifted partial remainder.  The partial is
   // always below the divisor between steps, so its top bit is dropped.
   always_comb begin
      shifted     = {partial[DIVISOR_W-1:0], next_bit};
      divisor_ext = {1'b0, divisor};
      new_partial = shifted;
      q_bit       = 1'b0;
      if (shifted >= divisor_ext) begin
         new_partial = shifted - divisor_ext;
         q_bit       = 1'b1;
      end
   end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_DIV_ZERO_EN: a zero divisor skips the iteration
// and reports quotient/remainder all-ones with dz set.
//
// Handshake: start is a request sampled only while idle (busy=0, done=0);
// it is otherwise ignored and never queued.  done is a single-cycle pulse,
// and quotient/remainder/dz are valid while done is high and stay held
// until the next accepted request completes.
module seq_divider
   import seq_div_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  busy,
   output logic                  done,
   output logic                  dz,
   output state_e                dbg_state
);

   state_e                state_q, state_d;
   logic [COUNT_W-1:0]    count_q, count_d;
   logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
   logic [PARTIAL_W-1:0]  partial_q, partial_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;

   logic [PARTIAL_W-1:0]  step_partial;
   logic                  step_q_bit;

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   logic                  dz_q, dz_d;
   logic                  zero_pend_q, zero_pend_d;
`endif

   div_step u_div_step (
      .partial     (partial_q),
      .next_bit    (dvd_q[DIVIDEND_W-1]),
      .divisor     (dsr_q),
      .new_partial (step_partial),
      .q_bit       (step_q_bit)
   );

   // Next-state and datapath update for IDLE/RUN/DONE.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      dvd_d       = dvd_q;
      dsr_d       = dsr_q;
      partial_d   = partial_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
      dz_d        = dz_q;
      zero_pend_d = zero_pend_q;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
            // A zero divisor spends one more IDLE cycle, then jumps to DONE
            // with the saturated result instead of iterating.
            if (zero_pend_q) begin
               zero_pend_d = 1'b0;
               state_d     = ST_DONE;
               quotient_d  = '1;
               remainder_d = '1;
               dz_d        = 1'b1;
            end else if (start) begin
               dvd_d     = dividend;
               dsr_d     = divisor;
               partial_d = '0;
               count_d   = COUNT_W'(STEP_COUNT);
               if (divisor == '0) begin
                  zero_pend_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
`else
            if (start) begin
               dvd_d     = dividend;
               dsr_d     = divisor;
               partial_d = '0;
               count_d   = COUNT_W'(STEP_COUNT);
               state_d   = ST_RUN;
            end
`endif
         end

         ST_RUN: begin
            // The dividend register shifts out its MSB and collects the
            // quotient bits from the right; after the last step it holds
            // the full quotient.
            partial_d = step_partial;
            dvd_d     = {dvd_q[DIVIDEND_W-2:0], step_q_bit};
            count_d   = count_q - COUNT_W'(1);
            if (count_q == COUNT_W'(1)) begin
               state_d     = ST_DONE;
               quotient_d  = {dvd_q[DIVIDEND_W-2:0], step_q_bit};
               remainder_d = step_partial[DIVISOR_W-1:0];
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
               dz_d        = 1'b0;
`endif
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         partial_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         partial_q   <= partial_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   // Divide-by-zero flag and the pending-zero marker.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dz_q        <= 1'b0;
         zero_pend_q <= 1'b0;
      end else begin
         dz_q        <= dz_d;
         zero_pend_q <= zero_pend_d;
      end
   end

   assign dz = dz_q;
`else
   assign dz = 1'b0;
`endif

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign dbg_state = state_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed and random checks for seq_divider against an arithmetic model.
module tb_seq_divider;
   import seq_div_pkg::*;

`ifdef SEQ_DIVIDER_DIV_ZERO_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        busy;
   logic        done;
   logic        dz;
   state_e      dbg_state;

   // expected {dz, quotient, remainder} per accepted request
   logic [24:0] exp_q[$];

   int          n_tests;
   int          n_fail;
   int          edge_cnt;
   int          acc_edge;
   bit          acc_zero;
   logic [15:0] last_quot;
   logic [7:0]  last_rem;

   seq_divider dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .dz        (dz),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_cnt = edge_cnt + 1;

   // reference model: plain integer division plus the zero-divisor rule
   function automatic logic [24:0] ref_div(input logic [15:0] a, input logic [7:0] b);
      logic [15:0] q;
      logic [15:0] r;
      if (b == 8'd0) begin
         if (DZ_EN) return {1'b1, 16'hFFFF, 8'hFF};
         else       return {1'b0, 16'hFFFF, a[7:0]};
      end
      q = a / {8'd0, b};
      r = a % {8'd0, b};
      return {1'b0, q, r[7:0]};
   endfunction

   function automatic int lat_now();
      return acc_zero ? 1 : 16;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // driver tasks: all are entered just after a falling edge
   task automatic issue_op(input logic [15:0] a, input logic [7:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      acc_edge = edge_cnt + 1;
      acc_zero = DZ_EN && (b == 8'd0);
      exp_q.push_back(ref_div(a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_start(input logic [15:0] a, input logic [7:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // returns in the IDLE cycle right after the done pulse
   task automatic wait_op();
      while (edge_cnt < acc_edge + lat_now() + 1) @(negedge clk);
   endtask

   task automatic chk_result(input string name, input logic [15:0] q, input logic [7:0] r,
                             input logic d);
      chk({name, "_quot"}, 32'(quotient), 32'(q));
      chk({name, "_rem"}, 32'(remainder), 32'(r));
      chk({name, "_dz_held"}, 32'(dz), 32'(d & DZ_EN));
   endtask

   // compare process: timing and held-result checks after every edge
   initial begin : compare
      int          e;
      bit          busy_exp;
      bit          done_exp;
      logic [24:0] x;
      forever begin
         @(posedge clk);
         #1;
         e        = edge_cnt;
         busy_exp = (acc_edge >= 0) && !acc_zero && (e >= acc_edge) && (e < acc_edge + 16);
         done_exp = (acc_edge >= 0) && (e == acc_edge + lat_now());
         if (done_exp) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL scoreboard_empty: got 0 entries expected 1 (edge %0d)", e);
            end else begin
               x         = exp_q.pop_front();
               last_quot = x[23:8];
               last_rem  = x[7:0];
               chk("dz_at_done", 32'(dz), 32'(x[24]));
            end
         end
         chk("busy", 32'(busy), 32'(busy_exp));
         chk("done", 32'(done), 32'(done_exp));
         chk("quotient", 32'(quotient), 32'(last_quot));
         chk("remainder", 32'(remainder), 32'(last_rem));
      end
   end

   // stimulus sequence and final report
   initial begin : main
      logic [15:0] ra;
      logic [7:0]  rb;
      n_tests   = 0;
      n_fail    = 0;
      edge_cnt  = 0;
      acc_edge  = -1;
      acc_zero  = 1'b0;
      last_quot = '0;
      last_rem  = '0;
      start     = 1'b0;
      dividend  = '0;
      divisor   = '0;
      reset     = 1'b1;
      #2 reset  = 1'b0;

      // pin the model with hand-computed values
      chk("pin_1000_7", 32'(ref_div(16'd1000, 8'd7)), 32'({1'b0, 16'd142, 8'd6}));
      chk("pin_ffff_ff", 32'(ref_div(16'hFFFF, 8'hFF)), 32'({1'b0, 16'h0101, 8'h00}));
      chk("pin_ffff_01", 32'(ref_div(16'hFFFF, 8'h01)), 32'({1'b0, 16'hFFFF, 8'h00}));
      chk("pin_5_10", 32'(ref_div(16'h0005, 8'h0A)), 32'({1'b0, 16'h0000, 8'h05}));
      chk("pin_100_9", 32'(ref_div(16'd100, 8'd9)), 32'({1'b0, 16'd11, 8'd1}));

      repeat (2) @(negedge clk);
      chk("rst_quot", 32'(quotient), 32'd0);
      chk("rst_rem", 32'(remainder), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dz", 32'(dz), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b1;
      @(negedge clk);

      // basic operation and fixed latency
      issue_op(16'd1000, 8'd7);
      wait_op();
      chk_result("op_1000_7", 16'd142, 8'd6, 1'b0);

      issue_op(16'hFFFF, 8'hFF);
      wait_op();
      chk_result("op_ffff_ff", 16'h0101, 8'h00, 1'b0);

      issue_op(16'hFFFF, 8'h01);
      wait_op();
      chk_result("op_ffff_01", 16'hFFFF, 8'h00, 1'b0);

      issue_op(16'h0005, 8'h0A);
      wait_op();
      chk_result("op_5_10", 16'h0000, 8'h05, 1'b0);

      // zero divisor
      issue_op(16'h1234, 8'h00);
      wait_op();
      if (DZ_EN) chk_result("op_div0", 16'hFFFF, 8'hFF, 1'b1);
      else       chk_result("op_div0", 16'hFFFF, 8'h34, 1'b0);

      // start pulsed mid-RUN is ignored
      issue_op(16'd1000, 8'd7);
      repeat (4) @(negedge clk);
      pulse_start(16'd50, 8'd3);
      wait_op();
      chk_result("op_ignore_run", 16'd142, 8'd6, 1'b0);

      // start held during the DONE cycle is ignored
      issue_op(16'd200, 8'd9);
      while (edge_cnt < acc_edge + 16) @(negedge clk);
      pulse_start(16'd7, 8'd7);
      repeat (3) @(negedge clk);
      chk_result("op_ignore_done", 16'd22, 8'd2, 1'b0);

      // reset at RUN step 8 aborts the operation
      issue_op(16'd1000, 8'd7);
      while (edge_cnt < acc_edge + 8) @(negedge clk);
      reset     = 1'b0;
      acc_edge  = -1;
      acc_zero  = 1'b0;
      exp_q.delete();
      last_quot = '0;
      last_rem  = '0;
      #1;
      chk("abort_quot", 32'(quotient), 32'd0);
      chk("abort_rem", 32'(remainder), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_dz", 32'(dz), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      @(negedge clk);
      issue_op(16'd100, 8'd9);
      wait_op();
      chk_result("op_after_abort", 16'd11, 8'd1, 1'b0);

      // back-to-back random operands
      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = (i % 25 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
         issue_op(ra, rb);
         wait_op();
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_seq_divider
